// File: rtl/simt_register_bank.sv
// Per-lane SIMT register bank: one masked write port, NUM_RPORTS registered read ports with
// write-first bypass, and a post-reset zero sweep. Define SIMT_RBANK_PARITY_EN for per-entry even parity.
module simt_register_bank #(
    parameter int LANES      = 8,
    parameter int DEPTH      = 64,
    parameter int WIDTH      = 32,
    parameter int NUM_RPORTS = 2,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                                clk,
    input  logic                                rst,
    output logic                                ready,
    input  logic [LANES-1:0]                    write_en,
    input  logic [AW-1:0]                       waddr,
    input  logic [LANES*WIDTH-1:0]              wdata,
    input  logic [NUM_RPORTS*LANES-1:0]         read_en,
    input  logic [NUM_RPORTS*AW-1:0]            raddr,
`ifdef SIMT_RBANK_PARITY_EN
    input  logic [LANES-1:0]                    par_inject,
    output logic [NUM_RPORTS*LANES-1:0]         perr,
`endif
    output logic [NUM_RPORTS*LANES*WIDTH-1:0]   rdata,
    output logic [NUM_RPORTS*LANES-1:0]         rvalid
);

    typedef enum logic {INIT, RUN} state_t;

    state_t                              state_q, state_d;
    logic [AW-1:0]                       cnt_q;
    logic [WIDTH-1:0]                    mem [LANES][DEPTH];
    logic [LANES-1:0]                    wr_lane_en_p0;
    logic [AW-1:0]                       wr_addr_p0;
    logic [LANES*WIDTH-1:0]              wr_data_p0;
    logic [NUM_RPORTS*LANES*WIDTH-1:0]   rdata_p1;
    logic [NUM_RPORTS*LANES-1:0]         vld_p1;

    function automatic logic even_par(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    // ---- control: init sweep FSM ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT)
                cnt_q <= cnt_q + AW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    if (cnt_q == AW'(DEPTH - 1)) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    assign ready = (state_q == RUN);

    // ---- stage p0: write port select (sweep vs. external) ----
    always_comb begin
        wr_lane_en_p0 = '0;
        wr_addr_p0    = waddr;
        wr_data_p0    = wdata;
        if (!rst) begin
            if (state_q == INIT) begin
                wr_lane_en_p0 = '1;
                wr_addr_p0    = cnt_q;
                wr_data_p0    = '0;
            end else begin
                wr_lane_en_p0 = write_en;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++)
            if (wr_lane_en_p0[i])
                mem[i][wr_addr_p0] <= wr_data_p0[i*WIDTH +: WIDTH];
    end

`ifdef SIMT_RBANK_PARITY_EN
    logic                        mem_par [LANES][DEPTH];
    logic [LANES-1:0]            wr_par_p0;
    logic [NUM_RPORTS*LANES-1:0] perr_p1;

    always_comb begin
        for (int i = 0; i < LANES; i++)
            wr_par_p0[i] = even_par(wr_data_p0[i*WIDTH +: WIDTH]) ^ (ready & par_inject[i]);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++)
            if (wr_lane_en_p0[i])
                mem_par[i][wr_addr_p0] <= wr_par_p0[i];
    end

    assign perr = perr_p1;
`endif

    // ---- stage p1: registered read with write-first bypass ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_p1 <= '0;
            vld_p1   <= '0;
`ifdef SIMT_RBANK_PARITY_EN
            perr_p1  <= '0;
`endif
        end else begin
            for (int p = 0; p < NUM_RPORTS; p++) begin
                for (int i = 0; i < LANES; i++) begin
                    vld_p1[p*LANES+i] <= ready && read_en[p*LANES+i];
`ifdef SIMT_RBANK_PARITY_EN
                    perr_p1[p*LANES+i] <= 1'b0;
`endif
                    if (ready && read_en[p*LANES+i]) begin
                        if (write_en[i] && (raddr[p*AW +: AW] == waddr)) begin
                            rdata_p1[(p*LANES+i)*WIDTH +: WIDTH] <= wdata[i*WIDTH +: WIDTH];
                        end else begin
                            rdata_p1[(p*LANES+i)*WIDTH +: WIDTH] <= mem[i][raddr[p*AW +: AW]];
`ifdef SIMT_RBANK_PARITY_EN
                            perr_p1[p*LANES+i] <= even_par(mem[i][raddr[p*AW +: AW]])
                                                  ^ mem_par[i][raddr[p*AW +: AW]];
`endif
                        end
                    end
                end
            end
        end
    end

    assign rdata  = rdata_p1;
    assign rvalid = vld_p1;

endmodule

// File: tb/tb_simt_register_bank.sv
// Directed testbench for simt_register_bank (default parameters); parity steps build with SIMT_RBANK_PARITY_EN.
module tb_simt_register_bank;

    localparam int LANES = 8;
    localparam int DEPTH = 64;
    localparam int WIDTH = 32;
    localparam int NP    = 2;
    localparam int AW    = 6;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      ready;
    logic [LANES-1:0]          write_en;
    logic [AW-1:0]             waddr;
    logic [LANES*WIDTH-1:0]    wdata;
    logic [NP*LANES-1:0]       read_en;
    logic [NP*AW-1:0]          raddr;
    logic [NP*LANES*WIDTH-1:0] rdata;
    logic [NP*LANES-1:0]       rvalid;
`ifdef SIMT_RBANK_PARITY_EN
    logic [LANES-1:0]          par_inject;
    logic [NP*LANES-1:0]       perr;
`endif

    int checks = 0;
    int errors = 0;

    simt_register_bank #(
        .LANES(LANES), .DEPTH(DEPTH), .WIDTH(WIDTH), .NUM_RPORTS(NP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ready(ready),
        .write_en(write_en),
        .waddr(waddr),
        .wdata(wdata),
        .read_en(read_en),
        .raddr(raddr),
`ifdef SIMT_RBANK_PARITY_EN
        .par_inject(par_inject),
        .perr(perr),
`endif
        .rdata(rdata),
        .rvalid(rvalid)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] fill(input logic [31:0] v);
        return {8{v}};
    endfunction

    logic [255:0] seq_v, mix_v, p1_v, cafe_v;
    int n;
    logic saw_valid;

    initial begin
        rst = 1'b1; write_en = '0; waddr = '0; wdata = '0; read_en = '0; raddr = '0;
`ifdef SIMT_RBANK_PARITY_EN
        par_inject = '0;
`endif
        for (int i = 0; i < LANES; i++) seq_v[i*32 +: 32] = 32'h1000_0000 + 32'(i);

        // Reset state
        tick;
        check("rst_ready", 512'(ready), 512'd0);
        check("rst_rvalid", 512'(rvalid), 512'd0);
        check("rst_rdata", rdata, 512'd0);

        // Init sweep length
        rst = 1'b0;
        n = 0;
        while (!ready && n < 200) begin tick; n++; end
        check("init_cycles", 512'(n), 512'd64);

        // Every address reads zero on both ports
        for (int a = 0; a < DEPTH; a++) begin
            read_en = '1;
            raddr   = {AW'(a), AW'(a)};
            tick;
            check("zero_rvalid", 512'(rvalid), 512'hFFFF);
            check("zero_rdata", rdata, 512'd0);
        end
        read_en = '0;

        // Mid-init reset: writes/reads ignored, full sweep restarts
        rst = 1'b1; tick; rst = 1'b0;
        repeat (30) tick;
        rst = 1'b1; tick; rst = 1'b0;
        write_en = '1; waddr = 6'h10; wdata = fill(32'hA5A5A5A5);
        read_en = '1; raddr = {6'h10, 6'h10};
        n = 0; saw_valid = 1'b0;
        while (!ready && n < 200) begin
            tick; n++;
            if (rvalid != '0) saw_valid = 1'b1;
        end
        write_en = '0;
        check("midinit_cycles", 512'(n), 512'd64);
        check("midinit_no_rvalid", 512'(saw_valid), 512'd0);
        tick;
        check("midinit_rvalid", 512'(rvalid), 512'hFFFF);
        check("midinit_rdata", rdata, 512'd0);
        read_en = '0;

        // Write all lanes, then read on both ports
        write_en = 8'hFF; waddr = 6'h05; wdata = seq_v;
        tick;
        write_en = '0; read_en = 16'hFFFF; raddr = {6'h05, 6'h05};
        tick;
        check("all_rvalid", 512'(rvalid), 512'hFFFF);
        check("all_rdata", rdata, {seq_v, seq_v});

        // rvalid drops, rdata holds when read_en clear
        read_en = '0;
        tick;
        check("idle_rvalid", 512'(rvalid), 512'd0);
        check("idle_hold", rdata, {seq_v, seq_v});

        // Partial lanes with write-first bypass
        write_en = 8'hFF; waddr = 6'h3F; wdata = fill(32'h11111111);
        tick;
        write_en = 8'h0F; wdata = fill(32'h22222222);
        read_en = 16'h00FF; raddr = {6'h00, 6'h3F};
        tick;
        write_en = '0; read_en = '0;
        mix_v = {fill(32'h11111111)};
        for (int i = 0; i < 4; i++) mix_v[i*32 +: 32] = 32'h22222222;
        check("bypass_rvalid", 512'(rvalid), 512'h00FF);
        check("bypass_rdata", rdata, {seq_v, mix_v});
        read_en = 16'h00FF; raddr = {6'h00, 6'h3F};
        tick;
        check("partial_stored", rdata, {seq_v, mix_v});

        // Read-enable gating on port 1
        read_en = 16'h8100; raddr = {6'h3F, 6'h00};
        tick;
        read_en = '0;
        p1_v = seq_v;
        p1_v[0*32 +: 32] = 32'h22222222;
        p1_v[7*32 +: 32] = 32'h11111111;
        check("gate_rvalid", 512'(rvalid), 512'h8100);
        check("gate_rdata", rdata, {p1_v, mix_v});

        // Address 0 boundary and both ports on the same address
        cafe_v = fill(32'hCAFEF00D);
        cafe_v[5*32 +: 32] = 32'h0BADBEEF;
        write_en = 8'hFF; waddr = 6'h00; wdata = cafe_v;
        tick;
        write_en = '0; read_en = 16'hFFFF; raddr = {6'h00, 6'h00};
        tick;
        check("same_addr", rdata, {cafe_v, cafe_v});
        raddr = {6'h00, 6'h3F};
        tick;
        read_en = '0;
        check("edge_addrs", rdata, {cafe_v, mix_v});

`ifdef SIMT_RBANK_PARITY_EN
        // Injected parity error on lane 3, then clean rewrite
        write_en = 8'h08; waddr = 6'h02; wdata = '0; wdata[3*32 +: 32] = 32'h12345678;
        par_inject = 8'h08;
        tick;
        write_en = '0; par_inject = '0;
        read_en = 16'h00FF; raddr = {6'h00, 6'h02};
        tick;
        check("perr_inject", 512'(perr), 512'h0008);
        check("perr_rvalid", 512'(rvalid), 512'h00FF);
        read_en = '0;
        write_en = 8'h08;
        tick;
        write_en = '0; read_en = 16'h00FF;
        tick;
        check("perr_clean", 512'(perr), 512'h0000);
        // Bypassed read never flags, even with injection
        write_en = 8'h08; par_inject = 8'h08; read_en = 16'h00FF;
        tick;
        write_en = '0; par_inject = '0; read_en = '0;
        check("perr_bypass", 512'(perr), 512'h0000);
        tick;
        check("perr_idle", 512'(perr), 512'h0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
